relu_backward: RTL
==================

Name: relu_backward

Overview:
- Gradient-side counterpart of the forward ReLU activation, used for on-chip training.
- Forward pass:
  - applies ReLU to a stream of pre-activations;
  - records one mask bit per element (data > THRESHOLD) in an internal FIFO.
- Backward pass:
  - consumes the gradient stream in the same element order;
  - passes each gradient where its mask bit is 1 and forces 0 where it is 0.
- Sits between a conv/FC layer and its gradient engine, with valid/ready streams on all four sides.

Parameters:
- BITWIDTH, 8, signed width of activation and gradient words.
- THRESHOLD, 0, signed clamp level; forward output = data > THRESHOLD ? data : THRESHOLD.
- DEPTH, 1024, mask entries held (maximum in-flight elements between forward and backward).
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clear  in  1  synchronous flush of mask FIFO and both output registers
- fwd_valid  in  1  pre-activation valid
- fwd_ready  out  1  pre-activation accepted when high with fwd_valid
- fwd_data  in  BITWIDTH  signed pre-activation
- act_valid  out  1  ReLU output valid
- act_ready  in  1  downstream ready
- act_data  out  BITWIDTH  signed ReLU output
- grad_valid  in  1  incoming gradient valid
- grad_ready  out  1  gradient accepted when high with grad_valid
- grad_data  in  BITWIDTH  signed incoming gradient
- dgrad_valid  out  1  masked gradient valid
- dgrad_ready  in  1  downstream ready
- dgrad_data  out  BITWIDTH  signed masked gradient
- count  out  CNT_W  mask entries stored
- full  out  1  count == DEPTH
- empty  out  1  count == 0

Behaviour:
- Reset (rst_n low, asynchronous):
  - act_valid = dgrad_valid = 0;
  - act_data = dgrad_data = 0;
  - write/read pointers = 0, count = 0, empty = 1, full = 0.
- Mask storage: DEPTH x 1 bit.
  - Pointers wrap to 0 after DEPTH-1; explicit compare, so any DEPTH >= 2 is legal.
- Forward path:
  - fwd_ready = !full && (!act_valid || act_ready).
  - On fwd accept:
    - mask[wr_ptr] <= (fwd_data > THRESHOLD), signed compare;
    - wr_ptr advances;
    - act_data <= ReLU(fwd_data);
    - act_valid <= 1.
  - act_valid drops when act_ready && !new accept. Latency 1 cycle; full throughput of 1 per cycle.
  - act_data holds stable while act_valid && !act_ready.
- Backward path:
  - grad_ready = !empty && (!dgrad_valid || dgrad_ready).
  - On grad accept:
    - dgrad_data <= mask[rd_ptr] ? grad_data : 0;
    - rd_ptr advances;
    - dgrad_valid <= 1.
  - Latency 1 cycle; 1 per cycle. dgrad_data holds while stalled.
- Equality at THRESHOLD: mask bit 0. Gradient blocked; forward output = THRESHOLD.
- Count:
  - +1 on fwd accept only;
  - -1 on grad accept only;
  - unchanged on simultaneous accept.
  - full/empty derived from count, registered alongside it.
- Simultaneous push and pop when empty:
  - grad_ready is 0 (empty), so the pop is not taken.
  - The same-cycle write is not bypassed; the bit becomes visible next cycle.
- Simultaneous push and pop when full:
  - fwd_ready is 0, so no push.
  - The pop frees a slot from the next cycle.
- clear (synchronous, highest priority over accepts):
  - pointers and count to 0;
  - act_valid = dgrad_valid = 0;
  - fwd_ready = grad_ready = 0 during the clear cycle.
  - Mask contents are not zeroed (don't care).
- Reset mid-operation: all in-flight outputs and stored mask bits are discarded immediately.
- No arithmetic widening: all data paths are BITWIDTH. Masking is a select, no overflow possible.

Decomposition:
- Shared package cnn_pkg:
  - default BITWIDTH;
  - a signed-compare/ReLU function reused by the forward ReLU, this block and pooling.
- Sub-module mask_fifo (1-bit synchronous FIFO):
  - ports: push, pop, din, dout, count, full, empty, clear;
  - holds the pointers, wrap and count logic.
- relu_backward holds the two output skid registers and the ready logic.

Test Plan:
- Forward, BITWIDTH=8, THRESHOLD=0, outputs always ready:
  - fwd_data = 5, -3, 0, 127, -128 → act_data = 5, 0, 0, 127, 0, each 1 cycle later;
  - count = 5, mask = 1, 0, 0, 1, 0.
- Backward after the previous scenario:
  - grad_data = 10, 20, 30, 40, 50 → dgrad_data = 10, 0, 0, 40, 0;
  - count ends 0, empty = 1, grad_ready = 0.
- Full boundary, DEPTH=4:
  - push 4 elements → full = 1, fwd_ready = 0;
  - 5th fwd_valid is held and not accepted;
  - one grad accept → fwd_ready = 1 next cycle.
- Simultaneous push and pop at count = 2 → count stays 2; pointers each advance by 1; wrap past index 3 correct.
- Backpressure:
  - act_ready = 0 for 3 cycles with act_valid = 1 → act_data stable, fwd_ready = 0;
  - same check on dgrad_ready / dgrad_data.
- Clear and reset: with count = 3 and both outputs valid, assert clear for 1 cycle (or pulse rst_n low mid-cycle) → count 0, empty 1, act_valid = dgrad_valid = 0; outputs forced 0 asynchronously on rst_n.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath blocks: default word width and the
// thresholded ReLU helpers used by the forward activation, backward mask and pooling.
package cnn_pkg;

    localparam int unsigned DEF_BITWIDTH = 8;

    // Signed "strictly above threshold" test; equality counts as clamped.
    function automatic logic relu_pass(input int signed data, input int signed thresh);
        return data > thresh;
    endfunction

    // Thresholded ReLU on sign-extended operands; callers size-cast the result back.
    function automatic int signed relu(input int signed data, input int signed thresh);
        return (data > thresh) ? data : thresh;
    endfunction

endpackage

// File: rtl/mask_fifo.sv
// One-bit-wide synchronous FIFO holding ReLU mask bits between the forward and
// backward passes. Pointers wrap by explicit compare so any DEPTH >= 2 works.
// Callers only push when not full and only pop when not empty.
module mask_fifo #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic             din,
    output logic             dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic             r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_empty;

    logic [PTR_W-1:0] w_wr_ptr_d;
    logic [PTR_W-1:0] w_rd_ptr_d;
    logic [CNT_W-1:0] w_count_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    // Storage is never reset; stale bits are unreachable once pointers and count clear.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Next-state for pointers and occupancy; clear overrides any push/pop.
    always_comb begin
        w_wr_ptr_d = r_wr_ptr;
        w_rd_ptr_d = r_rd_ptr;
        w_count_d  = r_count;
        if (clear) begin
            w_wr_ptr_d = '0;
            w_rd_ptr_d = '0;
            w_count_d  = '0;
        end else begin
            if (push) begin
                w_wr_ptr_d = ptr_inc(r_wr_ptr);
            end
            if (pop) begin
                w_rd_ptr_d = ptr_inc(r_rd_ptr);
            end
            if (push && !pop) begin
                w_count_d = r_count + 1'b1;
            end else if (pop && !push) begin
                w_count_d = r_count - 1'b1;
            end
        end
    end

    // Pointer, count and registered full/empty flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            r_wr_ptr <= w_wr_ptr_d;
            r_rd_ptr <= w_rd_ptr_d;
            r_count  <= w_count_d;
            r_full   <= (w_count_d == CNT_W'(DEPTH));
            r_empty  <= (w_count_d == '0);
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign count = r_count;
    assign full  = r_full;
    assign empty = r_empty;

endmodule

// File: rtl/relu_backward.sv
// Forward ReLU with mask capture plus backward gradient masking. Each forward
// element stores one mask bit; each gradient consumes one bit in the same order
// and is passed through or zeroed. Both outputs are single-entry registers.
module relu_backward
    import cnn_pkg::*;
#(
    parameter int unsigned BITWIDTH  = DEF_BITWIDTH,
    parameter int          THRESHOLD = 0,
    parameter int unsigned DEPTH     = 1024,
    parameter int unsigned CNT_W     = $clog2(DEPTH) + 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       fwd_valid,
    output logic                       fwd_ready,
    input  logic signed [BITWIDTH-1:0] fwd_data,
    output logic                       act_valid,
    input  logic                       act_ready,
    output logic signed [BITWIDTH-1:0] act_data,
    input  logic                       grad_valid,
    output logic                       grad_ready,
    input  logic signed [BITWIDTH-1:0] grad_data,
    output logic                       dgrad_valid,
    input  logic                       dgrad_ready,
    output logic signed [BITWIDTH-1:0] dgrad_data,
    output logic [CNT_W-1:0]           count,
    output logic                       full,
    output logic                       empty
);

    logic                       r_act_valid;
    logic signed [BITWIDTH-1:0] r_act_data;
    logic                       r_dgrad_valid;
    logic signed [BITWIDTH-1:0] r_dgrad_data;

    logic                       w_fwd_ready;
    logic                       w_grad_ready;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_mask_in;
    logic                       w_mask_out;
    logic                       w_full;
    logic                       w_empty;
    logic signed [BITWIDTH-1:0] w_act_next;
    logic signed [BITWIDTH-1:0] w_dgrad_next;

    // An output slot is free when empty or being drained this cycle; clear blocks accepts.
    assign w_fwd_ready  = !clear && !w_full && (!r_act_valid || act_ready);
    assign w_grad_ready = !clear && !w_empty && (!r_dgrad_valid || dgrad_ready);
    assign w_push       = fwd_valid && w_fwd_ready;
    assign w_pop        = grad_valid && w_grad_ready;

    assign w_mask_in    = relu_pass(int'(fwd_data), THRESHOLD);
    assign w_act_next   = BITWIDTH'(relu(int'(fwd_data), THRESHOLD));
    assign w_dgrad_next = w_mask_out ? grad_data : '0;

    mask_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) u_mask_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_mask_in),
        .dout  (w_mask_out),
        .count (count),
        .full  (w_full),
        .empty (w_empty)
    );

    // Activation output register: load on accept, drop valid once consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_act_valid <= 1'b0;
            r_act_data  <= '0;
        end else if (clear) begin
            r_act_valid <= 1'b0;
            r_act_data  <= '0;
        end else if (w_push) begin
            r_act_valid <= 1'b1;
            r_act_data  <= w_act_next;
        end else if (act_ready) begin
            r_act_valid <= 1'b0;
        end
    end

    // Masked-gradient output register: same handshake as the activation side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dgrad_valid <= 1'b0;
            r_dgrad_data  <= '0;
        end else if (clear) begin
            r_dgrad_valid <= 1'b0;
            r_dgrad_data  <= '0;
        end else if (w_pop) begin
            r_dgrad_valid <= 1'b1;
            r_dgrad_data  <= w_dgrad_next;
        end else if (dgrad_ready) begin
            r_dgrad_valid <= 1'b0;
        end
    end

    assign fwd_ready   = w_fwd_ready;
    assign grad_ready  = w_grad_ready;
    assign act_valid   = r_act_valid;
    assign act_data    = r_act_data;
    assign dgrad_valid = r_dgrad_valid;
    assign dgrad_data  = r_dgrad_data;
    assign full        = w_full;
    assign empty       = w_empty;

endmodule
